// File: rtl/dead_time_monitor_if.sv
// Gate-pair monitor bundle: raw gate feedback and control in,
// reconstructed PWM, dead-band telemetry and fault status out.
// Ports (slave view): gate_hi, gate_lo, dt_min, fault_clr in;
//   pwm_rec, dt_meas, dt_valid, dt_dir, viol, fault out.
interface dead_time_monitor_if #(
   parameter int DT_WIDTH = 8
);
   logic                gate_hi;
   logic                gate_lo;
   logic [DT_WIDTH-1:0] dt_min;
   logic                fault_clr;
   logic                pwm_rec;
   logic [DT_WIDTH-1:0] dt_meas;
   logic                dt_valid;
   logic                dt_dir;
   logic                viol;
   logic                fault;

   modport master (
      output gate_hi, gate_lo, dt_min, fault_clr,
      input  pwm_rec, dt_meas, dt_valid, dt_dir, viol, fault
   );

   modport slave (
      input  gate_hi, gate_lo, dt_min, fault_clr,
      output pwm_rec, dt_meas, dt_valid, dt_dir, viol, fault
   );
endinterface

// File: rtl/dead_time_monitor.sv
// Dead-time monitor: measures dead bands of a complementary gate
// pair, flags short bands, latches shoot-through, rebuilds PWM.
// Ports: clk, reset_n (async, active-low), bus (slave modport).
module dead_time_monitor #(
   parameter int DT_WIDTH    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   dead_time_monitor_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI_ON,
      S_DEAD_HL,
      S_LO_ON,
      S_DEAD_LH,
      S_FAULT
   } state_t;

   logic [SYNC_STAGES-1:0] sync_hi;
   logic [SYNC_STAGES-1:0] sync_lo;
   logic                   hs;
   logic                   ls;

   state_t              state, state_nxt;
   logic [DT_WIDTH-1:0] cnt, cnt_nxt;
   logic [DT_WIDTH-1:0] meas, meas_nxt;
   logic                pwm, pwm_nxt;
   logic                dir, dir_nxt;
   logic                valid, valid_nxt;
   logic                vio, vio_nxt;
   logic                flt, flt_nxt;
   logic                cnt_sat;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_hi <= '0;
         sync_lo <= '0;
      end else begin
         sync_hi <= {sync_hi[SYNC_STAGES-2:0], bus.gate_hi};
         sync_lo <= {sync_lo[SYNC_STAGES-2:0], bus.gate_lo};
      end
   end

   assign hs      = sync_hi[SYNC_STAGES-1];
   assign ls      = sync_lo[SYNC_STAGES-1];
   assign cnt_sat = &cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         meas  <= '0;
         pwm   <= 1'b0;
         dir   <= 1'b0;
         valid <= 1'b0;
         vio   <= 1'b0;
         flt   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         meas  <= meas_nxt;
         pwm   <= pwm_nxt;
         dir   <= dir_nxt;
         valid <= valid_nxt;
         vio   <= vio_nxt;
         flt   <= flt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      meas_nxt  = meas;
      pwm_nxt   = pwm;
      dir_nxt   = dir;
      valid_nxt = 1'b0;
      vio_nxt   = 1'b0;
      flt_nxt   = flt;
      // Overlap wins over every other transition.
      if (state != S_FAULT && hs && ls) begin
         state_nxt = S_FAULT;
         flt_nxt   = 1'b1;
         pwm_nxt   = 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (hs) begin
                  state_nxt = S_HI_ON;
                  pwm_nxt   = 1'b1;
               end else if (ls) begin
                  state_nxt = S_LO_ON;
                  pwm_nxt   = 1'b0;
               end
            end
            S_HI_ON: begin
               if (!hs) begin
                  state_nxt = S_DEAD_HL;
                  cnt_nxt   = DT_WIDTH'(1);
                  pwm_nxt   = 1'b0;
               end
            end
            S_LO_ON: begin
               if (!ls) begin
                  state_nxt = S_DEAD_LH;
                  cnt_nxt   = DT_WIDTH'(1);
                  pwm_nxt   = 1'b1;
               end
            end
            S_DEAD_HL: begin
               if (ls) begin
                  state_nxt = S_LO_ON;
                  meas_nxt  = cnt;
                  dir_nxt   = 1'b1;
                  valid_nxt = 1'b1;
                  vio_nxt   = (cnt < bus.dt_min);
               end else if (hs) begin
                  state_nxt = S_HI_ON;
                  pwm_nxt   = 1'b1;
               end else if (!cnt_sat) begin
                  cnt_nxt = cnt + DT_WIDTH'(1);
               end
            end
            S_DEAD_LH: begin
               if (hs) begin
                  state_nxt = S_HI_ON;
                  meas_nxt  = cnt;
                  dir_nxt   = 1'b0;
                  valid_nxt = 1'b1;
                  vio_nxt   = (cnt < bus.dt_min);
               end else if (ls) begin
                  state_nxt = S_LO_ON;
                  pwm_nxt   = 1'b0;
               end else if (!cnt_sat) begin
                  cnt_nxt = cnt + DT_WIDTH'(1);
               end
            end
            S_FAULT: begin
               pwm_nxt = 1'b0;
               // Clearing is only honoured once both gates are off.
               if (bus.fault_clr && !hs && !ls) begin
                  state_nxt = S_IDLE;
                  flt_nxt   = 1'b0;
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign bus.pwm_rec  = pwm;
   assign bus.dt_meas  = meas;
   assign bus.dt_valid = valid;
   assign bus.dt_dir   = dir;
   assign bus.viol     = vio;
   assign bus.fault    = flt;

endmodule

// File: tb/tb_dead_time_monitor.sv
// Directed bench for dead_time_monitor: an 8-bit instance plus a
// 4-bit instance (saturation) driven from the same gate pair.
module tb_dead_time_monitor;

   logic clk;
   logic reset_n;
   int   nchk;
   int   npass;
   int   vcnt;
   int   v0;

   dead_time_monitor_if #(.DT_WIDTH(8)) ifa ();
   dead_time_monitor_if #(.DT_WIDTH(4)) ifb ();

   dead_time_monitor #(.DT_WIDTH(8), .SYNC_STAGES(2)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifa)
   );

   dead_time_monitor #(.DT_WIDTH(4), .SYNC_STAGES(2)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifb)
   );

   assign ifb.gate_hi   = ifa.gate_hi;
   assign ifb.gate_lo   = ifa.gate_lo;
   assign ifb.fault_clr = ifa.fault_clr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial vcnt = 0;
   always @(negedge clk) if (ifa.dt_valid) vcnt = vcnt + 1;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   initial begin
      nchk          = 0;
      npass         = 0;
      reset_n       = 1'b0;
      ifa.gate_hi   = 1'b0;
      ifa.gate_lo   = 1'b0;
      ifa.fault_clr = 1'b0;
      ifa.dt_min    = 8'd4;
      ifb.dt_min    = 4'd15;
      tick(3);
      chk("rst_pwm", ifa.pwm_rec, 0);
      chk("rst_meas", ifa.dt_meas, 0);
      chk("rst_valid", ifa.dt_valid, 0);
      chk("rst_fault", ifa.fault, 0);
      reset_n = 1'b1;
      tick(2);

      // Test 1: HI->LO band of 5 cycles, dt_min 4
      ifa.gate_hi = 1'b1;
      tick(3);
      chk("t1_pwm_up", ifa.pwm_rec, 1);
      tick(7);
      ifa.gate_hi = 1'b0;
      tick(2);
      chk("t1_pwm_lag", ifa.pwm_rec, 1);
      tick(1);
      chk("t1_pwm_fall", ifa.pwm_rec, 0);
      tick(2);
      ifa.gate_lo = 1'b1;
      v0 = vcnt;
      tick(2);
      chk("t1_valid_early", ifa.dt_valid, 0);
      tick(1);
      chk("t1_valid", ifa.dt_valid, 1);
      chk("t1_meas", ifa.dt_meas, 5);
      chk("t1_dir", ifa.dt_dir, 1);
      chk("t1_viol", ifa.viol, 0);
      tick(1);
      chk("t1_valid_off", ifa.dt_valid, 0);
      chk("t1_meas_hold", ifa.dt_meas, 5);
      chk("t1_pulses", vcnt - v0, 1);

      // Test 2: LO->HI band of 5 cycles, dt_min 6 -> violation
      ifa.dt_min = 8'd6;
      tick(4);
      ifa.gate_lo = 1'b0;
      tick(5);
      ifa.gate_hi = 1'b1;
      tick(3);
      chk("t2_valid", ifa.dt_valid, 1);
      chk("t2_meas", ifa.dt_meas, 5);
      chk("t2_dir", ifa.dt_dir, 0);
      chk("t2_viol", ifa.viol, 1);
      chk("t2_pwm", ifa.pwm_rec, 1);
      tick(1);
      chk("t2_viol_off", ifa.viol, 0);
      chk("t2_valid_off", ifa.dt_valid, 0);

      // Test 5: aborted HI->LO band
      tick(4);
      v0 = vcnt;
      ifa.gate_hi = 1'b0;
      tick(2);
      ifa.gate_hi = 1'b1;
      tick(1);
      chk("t5_pwm_low", ifa.pwm_rec, 0);
      tick(1);
      chk("t5_pwm_low2", ifa.pwm_rec, 0);
      tick(1);
      chk("t5_pwm_back", ifa.pwm_rec, 1);
      tick(2);
      chk("t5_no_valid", vcnt - v0, 0);
      chk("t5_meas_hold", ifa.dt_meas, 5);

      // Test 3: 1-cycle overlap -> fault
      v0 = vcnt;
      ifa.gate_lo = 1'b1;
      tick(1);
      ifa.gate_lo = 1'b0;
      tick(1);
      chk("t3_fault_early", ifa.fault, 0);
      tick(1);
      chk("t3_fault", ifa.fault, 1);
      chk("t3_pwm", ifa.pwm_rec, 0);
      ifa.fault_clr = 1'b1;
      tick(3);
      chk("t3_clr_ignored", ifa.fault, 1);
      chk("t3_pwm_held", ifa.pwm_rec, 0);
      ifa.gate_hi = 1'b0;
      tick(2);
      chk("t3_fault_hold", ifa.fault, 1);
      tick(1);
      chk("t3_fault_clr", ifa.fault, 0);
      ifa.fault_clr = 1'b0;
      chk("t3_no_valid", vcnt - v0, 0);
      tick(2);
      chk("t3_idle_pwm", ifa.pwm_rec, 0);

      // Test 4: 20-cycle band, 4-bit instance saturates at 15
      ifa.dt_min = 8'd0;
      ifa.gate_hi = 1'b1;
      tick(5);
      ifa.gate_hi = 1'b0;
      tick(20);
      ifa.gate_lo = 1'b1;
      tick(3);
      chk("t4_b_valid", ifb.dt_valid, 1);
      chk("t4_b_meas", ifb.dt_meas, 15);
      chk("t4_b_viol", ifb.viol, 0);
      chk("t4_a_meas", ifa.dt_meas, 20);
      chk("t4_a_viol0", ifa.viol, 0);

      // Test 6: reset mid DEAD_HL discards the band
      tick(3);
      ifa.gate_lo = 1'b0;
      tick(4);
      ifa.gate_hi = 1'b1;
      tick(5);
      ifa.gate_hi = 1'b0;
      tick(5);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_meas", ifa.dt_meas, 0);
      chk("t6_rst_pwm", ifa.pwm_rec, 0);
      chk("t6_rst_dir", ifa.dt_dir, 0);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      v0 = vcnt;
      ifa.gate_lo = 1'b1;
      tick(5);
      chk("t6_no_valid", vcnt - v0, 0);
      ifa.gate_lo = 1'b0;
      tick(3);
      ifa.gate_hi = 1'b1;
      tick(3);
      chk("t6_valid", ifa.dt_valid, 1);
      chk("t6_meas", ifa.dt_meas, 3);
      chk("t6_dir", ifa.dt_dir, 0);
      tick(2);
      chk("t6_pulses", vcnt - v0, 1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
